// File: rtl/transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define TX_PARITY_EN to insert the even-parity bit (8E1); otherwise the frame is 8N1.
module transmitter #(
    parameter int CLK_DIV = 5208
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] parallel_data_in,
    output logic       serial_data_out,
    output logic       busy,
    output logic       tx_done
);

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLK_DIV - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   baud_q;
    logic [BW-1:0]   baud_d;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            line_q;
    logic            busy_q;
    logic            done_q;
    logic            bit_end;
`ifdef TX_PARITY_EN
    logic            parity_q;
`endif

    assign bit_end = (baud_q == BAUD_LAST);
    assign baud_d  = bit_end ? '0 : baud_q + 1'b1;

    // The line value for the next bit is registered at each bit boundary so the pin never glitches.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            line_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    line_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (tx_start) begin
                        shift_q  <= parallel_data_in;
`ifdef TX_PARITY_EN
                        parity_q <= ^parallel_data_in;
`endif
                        baud_q   <= '0;
                        bit_q    <= '0;
                        line_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        line_q  <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
                            line_q  <= parity_q;
                            state_q <= PARITY;
`else
                            line_q  <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            line_q <= shift_q[1];
                        end
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        line_q  <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    baud_q <= baud_d;
                    // Raised one cycle early so the registered pulse lands on the last stop cycle.
                    if (baud_q == BAUD_PRE) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    line_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign serial_data_out = line_q;
    assign busy            = busy_q;
    assign tx_done         = done_q;

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: acceptance and frame contents come from a timing/frame model.
module tb_transmitter;

    localparam int CLK_DIV = 4;
`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int NC = NBITS * CLK_DIV;
    localparam logic [63:0] EXP_BUSY = (64'd1 << NC) - 64'd1;
    localparam logic [63:0] EXP_DONE = 64'd1 << (NC - 1);

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] pdata = 8'h00;
    logic       serial_data_out;
    logic       busy;
    logic       tx_done;

    transmitter #(.CLK_DIV(CLK_DIV)) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .tx_start(tx_start),
        .parallel_data_in(pdata),
        .serial_data_out(serial_data_out),
        .busy(busy),
        .tx_done(tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         t;
    } frame_t;

    frame_t exp_q[$];
    int     tests = 0;
    int     fails = 0;
    int     next_free = 0;
    bit     mon_en = 1'b0;
    bit     in_frame = 1'b0;

    function automatic logic [63:0] exp_line(logic [7:0] b);
        int          bits[$];
        int          ones;
        logic [63:0] v;
        ones = 0;
        v = '0;
        bits.push_back(0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(int'(b[i]));
            ones += int'(b[i]);
        end
`ifdef TX_PARITY_EN
        bits.push_back(ones % 2);
`endif
        bits.push_back(1);
        for (int k = 0; k < NBITS; k++)
            for (int c = 0; c < CLK_DIV; c++)
                v[k*CLK_DIV + c] = bits[k][0];
        v[NC] = 1'b1;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One cycle of stimulus; the model accepts a request only when its own timing says the DUT is free.
    task automatic drive(bit s, logic [7:0] d);
        @(posedge sys_clk);
        #1;
        tx_start = s;
        pdata = d;
        if (rst_n && s && cyc >= next_free) begin
            exp_q.push_back('{d, cyc});
            next_free = cyc + NC + 1;
        end
    endtask

    frame_t      cur;
    int          idx;
    logic [63:0] al, ab, ad;

    always @(negedge sys_clk) begin
        if (!mon_en) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && busy) begin
                if (exp_q.size() == 0) begin
                    cur = '{8'h00, cyc - 1};
                    check("unexpected_frame", 64'd1, 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("start_cycle", 64'(cyc), 64'(cur.t + 1));
                end
                in_frame = 1'b1;
                idx = 0;
                al = '0;
                ab = '0;
                ad = '0;
            end
            if (in_frame) begin
                al[idx] = serial_data_out;
                ab[idx] = busy;
                ad[idx] = tx_done;
                idx++;
                if (idx == NC + 1) begin
                    check($sformatf("line_%02h", cur.data), al, exp_line(cur.data));
                    check("busy_window", ab, EXP_BUSY);
                    check("done_pulse", ad, EXP_DONE);
                    in_frame = 1'b0;
                end
            end else begin
                check("idle_line_done", {62'd0, serial_data_out, tx_done}, 64'd2);
                if (exp_q.size() > 0 && cyc > exp_q[0].t + 1) begin
                    check("start_timeout", 64'(cyc), 64'(exp_q[0].t + 1));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int w;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_line", 64'(serial_data_out), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(tx_done), 64'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(posedge sys_clk);
        #2;
        mon_en = 1'b1;

        drive(1'b1, 8'hA5);
        repeat (NC + 3) drive(1'b0, 8'($urandom));

        drive(1'b1, 8'h3C);
        repeat (9) drive(1'b0, 8'($urandom));
        drive(1'b1, 8'hFF);
        repeat (NC + 3) drive(1'b0, 8'($urandom));

        drive(1'b1, 8'h07);
        repeat (NC + 3) drive(1'b0, 8'($urandom));

        repeat (4 * (NC + 1)) drive(1'b1, 8'($urandom));
        repeat (NC + 3) drive(1'b0, 8'($urandom));

        repeat (1500) drive($urandom_range(0, 7) == 0, 8'($urandom));
        repeat (NC + 3) drive(1'b0, 8'h00);

        drive(1'b1, 8'hC3);
        repeat (16) drive(1'b0, 8'($urandom));
        @(posedge sys_clk);
        #2;
        check("busy_before_reset", 64'(busy), 64'd1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_line", 64'(serial_data_out), 64'd1);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(tx_done), 64'd0);
        exp_q.delete();
        tx_start = 1'b0;
        next_free = 0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(posedge sys_clk);
        #2;
        mon_en = 1'b1;

        drive(1'b1, 8'h55);
        repeat (NC + 3) drive(1'b0, 8'($urandom));

        w = 0;
        while ((exp_q.size() > 0 || in_frame) && w < 200) begin
            @(posedge sys_clk);
            w++;
        end
        check("drain_pending", 64'(exp_q.size() + int'(in_frame)), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
